cat_apb_loader: RTL and testbench
=================================

# cat_apb_loader

APB master stage that sits directly upstream of the CatRecognizer wrapper and drives its APB slave port. It accepts a valid/ready stream of image and weight words, writes each one to consecutive slave addresses, writes the start command to the control register, then waits on the recognizer's result output and returns a one-cycle result pulse. It turns a plain word stream into the complete APB load-and-run sequence the recognizer expects.

## Interface
Parameters:
- Amba_Word, 24, APB data width.
- Amba_Addr_Depth, 12, APB address width.
- DataBase, 1, first slave address written with stream data.
- CtrlAddr, 0, slave control register address.
- StartCmd, 1, value written to CtrlAddr to launch recognition.
- TimeoutCycles, 4096, maximum wait for a result after the start write.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_data  in  Amba_Word  stream word (pixel or weight).
- in_last  in  1  marks the final word of a frame.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write (always 1 when PSEL=1).
- PADDR  out  Amba_Addr_Depth  APB address.
- PWDATA  out  Amba_Word  APB write data.
- CatRecOut  in  2  recognizer output: bit1 = done, bit0 = cat.
- busy  out  1  frame in progress, from first accepted word until the result or timeout.
- result_valid  out  1  one-cycle pulse.
- result_cat  out  1  classification; held stable until the next pulse.
- error  out  1  sticky; set on address overflow or timeout, cleared by reset or at the next frame's first accepted word.

## Operation
- FSM states: IDLE, W_SETUP, W_ACCESS, C_SETUP, C_ACCESS, WAIT_RES, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid, the loader latches in_data and in_last into a holding register and goes to W_SETUP.
  - PADDR is driven from the address counter. The counter loads DataBase at the start of a frame.
- W_SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR=counter, PWDATA=held word.
- W_ACCESS:
  - PSEL=1, PENABLE=1, same address and data. There are no wait states and no PREADY.
  - Then the counter increments.
  - If the held word was last, go to C_SETUP; otherwise go to IDLE, which accepts the next word.
- Address overflow: the counter reaching 2^Amba_Addr_Depth−1 is the last legal data write.
  - A further non-last word sets error, is consumed with in_ready=1, and is not written.
  - Words keep being dropped until in_last, which still triggers the start write.
- C_SETUP/C_ACCESS: the same two-phase write with PADDR=CtrlAddr and PWDATA=StartCmd.
- WAIT_RES:
  - The timeout counter counts from 0.
  - On CatRecOut[1]=1, result_cat takes CatRecOut[0] and the FSM goes to REPORT.
  - If the counter reaches TimeoutCycles−1 without done, error sets, result_cat=0, and the FSM goes to REPORT.
- REPORT: result_valid=1 for one cycle, then IDLE.
- in_ready=0 in every state except IDLE. A word arriving while busy waits at the source per the valid/ready rules.
- Outside W_SETUP, W_ACCESS, C_SETUP and C_ACCESS: PSEL=PENABLE=PWRITE=0 and PADDR/PWDATA=0.

## Timing
- Reset values: FSM=IDLE, all APB outputs 0, in_ready=1, busy=0, result_valid=0, result_cat=0, error=0, counters 0.
- Reset asserted mid-transfer aborts immediately; the partial frame is discarded.
- Per-word throughput is 3 cycles: the accept cycle in IDLE, then SETUP, then ACCESS.
- For an N-word frame with the first accept at cycle 0:
  - the last data ACCESS is at cycle 3N−1;
  - the control SETUP is at 3N, and its ACCESS at 3N+1;
  - WAIT_RES begins at 3N+2.
- result_valid is asserted the cycle after done is sampled in WAIT_RES.
- in_valid is sampled only in IDLE. in_data must be stable only in the accept cycle.
- in_last with N=1 is legal: one data write, then the control write.
- CatRecOut[1] already high on entry to WAIT_RES is accepted in the first WAIT_RES cycle.

## Structure
- Shared package cat_apb_pkg holds:
  - the state enum for the loader's FSM;
  - default CtrlAddr, StartCmd and DataBase;
  - the CatRecOut bit indices (DONE_BIT=1, CAT_BIT=0).
- One sub-module, apb_write_phaser: drives the SETUP→ACCESS sequencing for a single address/data write and signals completion. It is used for both the data writes and the control write.
- The top holds the FSM, the address and timeout counters, the holding register and the result registers.

## Test plan
- 3-word frame 0x000011, 0x000022, 0x000033 (last) with in_valid held high:
  - writes 0x11@1, 0x22@2, 0x33@3, then 0x000001@0;
  - PSEL/PENABLE follow 1/0 then 1/1 for each write;
  - in_ready low except in the accept cycles.
- Same frame, CatRecOut=2'b11 five cycles after the control ACCESS → result_valid pulses for one cycle, result_cat=1, error=0, busy falls.
- CatRecOut never reaching done with TimeoutCycles=16 → after 16 cycles: result_valid=1, result_cat=0, error=1.
- Amba_Addr_Depth=3, 9-word frame:
  - data writes go to addresses 1..7;
  - the 8th word is dropped with error=1;
  - the 9th word (last) is dropped, and the control write still goes to 0.
- rst pulsed low during a W_ACCESS → all outputs go to 0 asynchronously and in_ready=1. A new 1-word frame after release completes normally.
- in_valid toggling with gaps of 0–4 cycles → the write sequence and addresses are identical to the back-to-back case; no word is lost or duplicated.

Source files
------------

// File: rtl/cat_apb_pkg.sv
// Shared types and defaults for the CatRecognizer APB loader.
// Holds the loader FSM encoding and recognizer output bit positions.
package cat_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_ACCESS,
    C_SETUP,
    C_ACCESS,
    WAIT_RES,
    REPORT
  } state_e;

  localparam int CTRL_ADDR_DEF = 0;
  localparam int START_CMD_DEF = 1;
  localparam int DATA_BASE_DEF = 1;

  localparam int DONE_BIT = 1;
  localparam int CAT_BIT  = 0;

endpackage

// File: rtl/cat_apb_loader_phaser.sv
// Two-phase APB write sequencer: SETUP on first req cycle, ACCESS next.
// Bus outputs are zero whenever no write is requested.
module apb_write_phaser #(
  parameter int AW = 12,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  output logic          done
);

  logic acc_q;
  logic acc_d;

  always_comb begin
    acc_d = req & ~acc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= 1'b0;
    else      acc_q <= acc_d;
  end

  assign psel    = req;
  assign pwrite  = req;
  assign penable = req & acc_q;
  assign done    = req & acc_q;
  assign paddr   = req ? addr : '0;
  assign pwdata  = req ? data : '0;

endmodule

// File: rtl/cat_apb_loader.sv
// Streams image/weight words into the CatRecognizer over APB,
// issues the start command and reports the recognition result.
module cat_apb_loader
  import cat_apb_pkg::*;
#(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 12,
  parameter int DataBase        = DATA_BASE_DEF,
  parameter int CtrlAddr        = CTRL_ADDR_DEF,
  parameter int StartCmd        = START_CMD_DEF,
  parameter int TimeoutCycles   = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Amba_Word-1:0]       in_data,
  input  logic                       in_last,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [Amba_Addr_Depth-1:0] PADDR,
  output logic [Amba_Word-1:0]       PWDATA,
  input  logic [1:0]                 CatRecOut,
  output logic                       busy,
  output logic                       result_valid,
  output logic                       result_cat,
  output logic                       error
);

  localparam int AW = Amba_Addr_Depth;
  localparam int DW = Amba_Word;
  localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  state_e        state_q, state_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          last_q, last_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_q, frame_d;
  logic          err_q, err_d;
  logic          cat_q, cat_d;

  logic          wreq;
  logic          ctrl;
  logic          wdone;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    frame_d  = frame_q;
    err_d    = err_q;
    cat_d    = cat_q;
    in_ready = 1'b0;
    wreq     = 1'b0;
    ctrl     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          frame_d = 1'b1;
          hold_d  = in_data;
          last_d  = in_last;
          if (!frame_q) begin
            cnt_d = AW'(DataBase);
            ovf_d = 1'b0;
            err_d = 1'b0;
          end
          // past the top address: swallow words, but last still starts
          if (frame_q && ovf_q) begin
            if (in_last) state_d = C_SETUP;
            else         err_d   = 1'b1;
          end else begin
            state_d = W_SETUP;
          end
        end
      end
      W_SETUP: begin
        wreq    = 1'b1;
        state_d = W_ACCESS;
      end
      W_ACCESS: begin
        wreq = 1'b1;
        if (wdone) begin
          cnt_d   = cnt_q + AW'(1);
          ovf_d   = ovf_q | (&cnt_q);
          state_d = last_q ? C_SETUP : IDLE;
        end
      end
      C_SETUP: begin
        wreq    = 1'b1;
        ctrl    = 1'b1;
        state_d = C_ACCESS;
      end
      C_ACCESS: begin
        wreq = 1'b1;
        ctrl = 1'b1;
        if (wdone) begin
          tmo_d   = '0;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (CatRecOut[DONE_BIT]) begin
          cat_d   = CatRecOut[CAT_BIT];
          frame_d = 1'b0;
          state_d = REPORT;
        end else if (tmo_q == TW'(TimeoutCycles - 1)) begin
          cat_d   = 1'b0;
          err_d   = 1'b1;
          frame_d = 1'b0;
          state_d = REPORT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      cat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      cat_q   <= cat_d;
    end
  end

  assign wr_addr = ctrl ? AW'(CtrlAddr) : cnt_q;
  assign wr_data = ctrl ? DW'(StartCmd) : hold_q;

  apb_write_phaser #(
    .AW (AW),
    .DW (DW)
  ) u_phaser (
    .clk     (clk),
    .rst     (rst),
    .req     (wreq),
    .addr    (wr_addr),
    .data    (wr_data),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .paddr   (PADDR),
    .pwdata  (PWDATA),
    .done    (wdone)
  );

  assign busy         = frame_q;
  assign result_valid = (state_q == REPORT);
  assign result_cat   = cat_q;
  assign error        = err_q;

endmodule

// File: tb/tb_cat_apb_loader.sv
// Bench for cat_apb_loader: cycle table, corner sequences, and
// randomized frames checked against a frame-level reference model.
module tb_cat_apb_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_last;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [2:0]  PADDR;
  logic [23:0] PWDATA;
  logic [1:0]  CatRecOut;
  logic        busy;
  logic        result_valid;
  logic        result_cat;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [26:0] wq[$];

  cat_apb_loader #(
    .Amba_Word       (24),
    .Amba_Addr_Depth (3),
    .TimeoutCycles   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .CatRecOut    (CatRecOut),
    .busy         (busy),
    .result_valid (result_valid),
    .result_cat   (result_cat),
    .error        (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (PSEL && PENABLE && PWRITE) wq.push_back({PADDR, PWDATA});
  end

  typedef struct {
    logic        v;
    logic [23:0] d;
    logic        l;
    logic [1:0]  cro;
    logic [34:0] exp;
  } vec_t;

  vec_t vec[18];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [34:0] ex(int r, int s, int e, int a, int d,
                                     int b, int rv, int rc, int er);
    return {1'(r), 1'(s), 1'(e), 1'(s), 3'(a), 24'(d),
            1'(b), 1'(rv), 1'(rc), 1'(er)};
  endfunction

  function automatic logic [34:0] outs();
    return {in_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
            busy, result_valid, result_cat, error};
  endfunction

  task automatic setv(input int i, input int v, input int d, input int l,
                      input int cro, input logic [34:0] e);
    vec[i].v   = 1'(v);
    vec[i].d   = 24'(d);
    vec[i].l   = 1'(l);
    vec[i].cro = 2'(cro);
    vec[i].exp = e;
  endtask

  task automatic push_word(input logic [23:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 64'(t < 50), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 24'($urandom);
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input int n, input int dly, input logic cat,
                           input bit rgap);
    logic [23:0] d[$];
    logic [26:0] ew[$];
    bit          xerr = 0;
    int          t;
    int          cyc;
    int          xlat;
    bit          got;
    wq.delete();
    for (int i = 0; i < n; i++) d.push_back(24'($urandom));
    for (int i = 0; i < n; i++) begin
      int a = 1 + i;
      if (a <= 7) ew.push_back({a[2:0], d[i]});
      else if (i != n - 1) xerr = 1;
    end
    ew.push_back({3'd0, 24'd1});
    if (dly > 15) xerr = 1;
    xlat = (dly > 15) ? 17 : ((dly < 0) ? 0 : dly) + 2;
    for (int i = 0; i < n; i++) begin
      int g = rgap ? int'($urandom_range(0, 4)) : 0;
      repeat (g) @(negedge clk);
      push_word(d[i], i == n - 1);
    end
    t = 0;
    while (!(PSEL && PENABLE && PADDR == 3'd0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ctrl_wait", 64'(t < 100), 64'd1);
    chk("busy_run", 64'(busy), 64'd1);
    if (dly < 0) CatRecOut = {1'b1, cat};
    cyc = 0;
    got = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (result_valid) begin
        got = 1;
        break;
      end
      if (dly >= 0 && cyc == dly + 1) CatRecOut = {1'b1, cat};
    end
    chk("res_seen", 64'(got), 64'd1);
    chk("res_lat", 64'(cyc), 64'(xlat));
    chk("res_cat", 64'(result_cat), 64'((dly > 15) ? 1'b0 : cat));
    chk("res_err", 64'(error), 64'(xerr));
    CatRecOut = 2'b00;
    @(negedge clk);
    chk("pulse_end", 64'(result_valid), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    chk("cat_hold", 64'(result_cat), 64'((dly > 15) ? 1'b0 : cat));
    chk("wr_count", 64'(wq.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < wq.size(); i++)
      chk($sformatf("wr%0d", i), 64'(wq[i]), 64'(ew[i]));
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    CatRecOut = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", 64'(outs()), 64'(ex(1,0,0,0,0,0,0,0,0)));
    @(negedge clk);
    rst = 1'b1;

    setv(0,  1, 'h11, 0, 0, ex(1,0,0,0,0,    0,0,0,0));
    setv(1,  1, 'h22, 0, 0, ex(0,1,0,1,'h11, 1,0,0,0));
    setv(2,  1, 'h22, 0, 0, ex(0,1,1,1,'h11, 1,0,0,0));
    setv(3,  1, 'h22, 0, 0, ex(1,0,0,0,0,    1,0,0,0));
    setv(4,  1, 'h33, 1, 0, ex(0,1,0,2,'h22, 1,0,0,0));
    setv(5,  1, 'h33, 1, 0, ex(0,1,1,2,'h22, 1,0,0,0));
    setv(6,  1, 'h33, 1, 0, ex(1,0,0,0,0,    1,0,0,0));
    setv(7,  0, 0,    0, 0, ex(0,1,0,3,'h33, 1,0,0,0));
    setv(8,  0, 0,    0, 0, ex(0,1,1,3,'h33, 1,0,0,0));
    setv(9,  0, 0,    0, 0, ex(0,1,0,0,1,    1,0,0,0));
    setv(10, 0, 0,    0, 0, ex(0,1,1,0,1,    1,0,0,0));
    setv(11, 0, 0,    0, 0, ex(0,0,0,0,0,    1,0,0,0));
    setv(12, 0, 0,    0, 0, ex(0,0,0,0,0,    1,0,0,0));
    setv(13, 0, 0,    0, 0, ex(0,0,0,0,0,    1,0,0,0));
    setv(14, 0, 0,    0, 0, ex(0,0,0,0,0,    1,0,0,0));
    setv(15, 0, 0,    0, 3, ex(0,0,0,0,0,    1,0,0,0));
    setv(16, 0, 0,    0, 3, ex(0,0,0,0,0,    0,1,1,0));
    setv(17, 0, 0,    0, 0, ex(1,0,0,0,0,    0,0,1,0));

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid  = vec[i].v;
      in_data   = vec[i].d;
      in_last   = vec[i].l;
      CatRecOut = vec[i].cro;
      #1;
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(vec[i].exp));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    CatRecOut = 2'b00;

    run_frame(1, 99, 1'b1, 0);
    run_frame(2, 15, 1'b1, 0);
    run_frame(9, 3, 1'b1, 0);
    run_frame(1, -1, 1'b0, 0);

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 24'hABCDEF;
    in_last  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    #1 rst = 1'b0;
    #1;
    chk("async_rst", 64'(outs()), 64'(ex(1,0,0,0,0,0,0,0,0)));
    @(negedge clk);
    rst = 1'b1;
    run_frame(1, 2, 1'b1, 0);

    for (int r = 0; r < 12; r++) begin
      int n   = int'($urandom_range(1, 9));
      int dly = int'($urandom_range(0, 22)) - 1;
      if (n == 8) n = 10;
      run_frame(n, dly, 1'($urandom_range(0, 1)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
